// File: rtl/pipeline_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_ctrl
//  Description : Central pipeline sequencer for the 5-stage 16-bit CPU.
//                Generates PC / pipeline-register write enables, the stage0
//                NOP-insert (flush) and stage1 bubble controls. Resolves
//                load-use hazards, taken-branch squashes and I/D cache-miss
//                freezes with a small FSM. Also keeps a saturating stall
//                counter and a sticky miss watchdog.
//  Ports       : clk, rst (async, active-low)
//                id_rs_addr/id_rt_addr/id_uses_rt   - ID-stage source operands
//                ex_mem_read/ex_rd_addr             - EX-stage load + dest
//                ex_branch_taken                    - branch resolved taken
//                icache_miss/dcache_miss/mem_ready  - memory-system status
//                pc_we, s0_we..s3_we, s0_flush, s1_bubble - pipeline controls
//                ctrl_state, stall_cycles, timeout_err    - status
//  Revision    : 1.0 - initial release
// ============================================================================
module pipeline_ctrl #(
   parameter bit          R0_ZERO = 1'b1,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  id_rs_addr,
   input  logic [3:0]  id_rt_addr,
   input  logic        id_uses_rt,
   input  logic        ex_mem_read,
   input  logic [3:0]  ex_rd_addr,
   input  logic        ex_branch_taken,
   input  logic        icache_miss,
   input  logic        dcache_miss,
   input  logic        mem_ready,
   output logic        pc_we,
   output logic        s0_we,
   output logic        s1_we,
   output logic        s2_we,
   output logic        s3_we,
   output logic        s0_flush,
   output logic        s1_bubble,
   output logic [1:0]  ctrl_state,
   output logic [15:0] stall_cycles,
   output logic        timeout_err
);

   localparam logic [7:0] c_TIMEOUT = TIMEOUT[7:0];

   typedef enum logic [1:0] {
      RUN         = 2'd0,
      IMISS       = 2'd1,
      IMISS_ABORT = 2'd2,
      DMISS       = 2'd3
   } state_t;

   state_t      r_state;
   state_t      w_next;
   logic [7:0]  r_miss_cnt;
   logic [7:0]  w_miss_inc;
   logic [15:0] r_stall;
   logic        r_timeout;

   logic w_load_use;
   logic w_freeze;
   logic w_fetch_hold;

   assign w_load_use = ex_mem_read
                     & ((ex_rd_addr == id_rs_addr) | (id_uses_rt & (ex_rd_addr == id_rt_addr)))
                     & ~(R0_ZERO & (ex_rd_addr == 4'd0));

   // A D-miss in any state stalls everything, including an in-flight I-miss.
   assign w_freeze     = dcache_miss | ((r_state == DMISS) & ~mem_ready);
   assign w_fetch_hold = (((r_state == IMISS) | (r_state == IMISS_ABORT)) & ~mem_ready)
                       | ((r_state == RUN) & icache_miss);

   // Mealy control outputs, forced inactive while reset is asserted
   always_comb begin
      pc_we     = 1'b1;
      s0_we     = 1'b1;
      s1_we     = 1'b1;
      s2_we     = 1'b1;
      s3_we     = 1'b1;
      s0_flush  = 1'b0;
      s1_bubble = 1'b0;
      if (!rst) begin
         pc_we = 1'b0;
         s0_we = 1'b0;
         s1_we = 1'b0;
         s2_we = 1'b0;
         s3_we = 1'b0;
      end else if (w_freeze) begin
         pc_we = 1'b0;
         s0_we = 1'b0;
         s1_we = 1'b0;
         s2_we = 1'b0;
         s3_we = 1'b0;
      end else if (ex_branch_taken) begin
         s0_flush  = 1'b1;
         s1_bubble = 1'b1;
      end else begin
         if (w_fetch_hold) begin
            pc_we    = 1'b0;
            s0_flush = 1'b1;
         end
         // Load-use hold overrides the fetch-hold flush: the ID instruction
         // must be kept, not replaced by a NOP.
         if (w_load_use) begin
            pc_we     = 1'b0;
            s0_we     = 1'b0;
            s0_flush  = 1'b0;
            s1_bubble = 1'b1;
         end
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         RUN: begin
            if (dcache_miss)          w_next = DMISS;
            else if (ex_branch_taken) w_next = RUN;   // wrong-path I-miss dropped
            else if (icache_miss)     w_next = IMISS;
         end
         IMISS: begin
            if (mem_ready)                         w_next = RUN;
            else if (ex_branch_taken && !w_freeze) w_next = IMISS_ABORT;
         end
         IMISS_ABORT: if (mem_ready) w_next = RUN;
         DMISS:       if (mem_ready) w_next = RUN;
         default:     w_next = RUN;
      endcase
   end

   assign w_miss_inc = (r_miss_cnt == 8'hFF) ? 8'hFF : (r_miss_cnt + 8'd1);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= RUN;
         r_miss_cnt <= 8'd0;
         r_stall    <= 16'd0;
         r_timeout  <= 1'b0;
      end else begin
         r_state <= w_next;
         if (!pc_we && (r_stall != 16'hFFFF))
            r_stall <= r_stall + 16'd1;
         // Every cycle spent outside RUN counts, including the refill cycle.
         if ((r_state != RUN) && (w_miss_inc == c_TIMEOUT))
            r_timeout <= 1'b1;
         if (w_next == RUN)
            r_miss_cnt <= 8'd0;
         else if (r_state != RUN)
            r_miss_cnt <= w_miss_inc;
      end
   end

   assign ctrl_state   = r_state;
   assign stall_cycles = r_stall;
   assign timeout_err  = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipeline_ctrl
//  Description : Scoreboard testbench for pipeline_ctrl. A driver applies
//                directed then random stimulus and pushes the reference
//                model's expected response; a monitor pops and compares.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_ctrl;

   localparam int TO = 10;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [3:0]  id_rs_addr = '0, id_rt_addr = '0, ex_rd_addr = '0;
   logic        id_uses_rt = 1'b0, ex_mem_read = 1'b0, ex_branch_taken = 1'b0;
   logic        icache_miss = 1'b0, dcache_miss = 1'b0, mem_ready = 1'b0;
   logic        pc_we, s0_we, s1_we, s2_we, s3_we, s0_flush, s1_bubble;
   logic [1:0]  ctrl_state;
   logic [15:0] stall_cycles;
   logic        timeout_err;

   pipeline_ctrl #(.R0_ZERO(1'b1), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst),
      .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr), .id_uses_rt(id_uses_rt),
      .ex_mem_read(ex_mem_read), .ex_rd_addr(ex_rd_addr),
      .ex_branch_taken(ex_branch_taken),
      .icache_miss(icache_miss), .dcache_miss(dcache_miss), .mem_ready(mem_ready),
      .pc_we(pc_we), .s0_we(s0_we), .s1_we(s1_we), .s2_we(s2_we), .s3_we(s3_we),
      .s0_flush(s0_flush), .s1_bubble(s1_bubble),
      .ctrl_state(ctrl_state), .stall_cycles(stall_cycles), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   // ctl = {pc_we, s0_we, s1_we, s2_we, s3_we, s0_flush, s1_bubble}
   typedef struct packed {
      logic [6:0]  ctl;
      logic [1:0]  st;
      logic [15:0] stall;
      logic        terr;
   } exp_t;

   exp_t q[$];
   int total = 0;
   int bad   = 0;

   // Reference model state: 0=RUN 1=IMISS 2=IMISS_ABORT 3=DMISS
   int m_state = 0;
   int m_run_len = 0;   // consecutive cycles spent outside RUN
   int m_stall = 0;
   bit m_terr  = 0;

   task automatic step(input logic r, input logic [3:0] rs, input logic [3:0] rt,
                       input logic ut, input logic emr, input logic [3:0] rd,
                       input logic br, input logic im, input logic dm, input logic mr);
      exp_t e;
      bit lu, frz, pc, s0, flush, bub, wea;
      int nxt;
      @(negedge clk);
      rst = r; id_rs_addr = rs; id_rt_addr = rt; id_uses_rt = ut;
      ex_mem_read = emr; ex_rd_addr = rd; ex_branch_taken = br;
      icache_miss = im; dcache_miss = dm; mem_ready = mr;
      #1;
      if (!r) begin
         m_state = 0; m_run_len = 0; m_stall = 0; m_terr = 0;
      end
      lu  = emr && (rd == rs || (ut && rd == rt)) && rd != 0;
      frz = dm || (m_state == 3 && !mr);
      wea = 1; pc = 1; s0 = 1; flush = 0; bub = 0;
      if (!r || frz) begin
         wea = 0; pc = 0; s0 = 0;
      end else if (br) begin
         flush = 1; bub = 1;
      end else begin
         if (((m_state == 1 || m_state == 2) && !mr) || (m_state == 0 && im)) begin
            pc = 0; flush = 1;
         end
         if (lu) begin
            pc = 0; s0 = 0; flush = 0; bub = 1;
         end
      end
      e.ctl   = {pc, s0, wea, wea, wea, flush, bub};
      e.st    = m_state[1:0];
      e.stall = m_stall[15:0];
      e.terr  = m_terr;
      q.push_back(e);
      @(posedge clk);
      if (r) begin
         case (m_state)
            0: nxt = dm ? 3 : (br ? 0 : (im ? 1 : 0));
            1: nxt = mr ? 0 : ((br && !dm) ? 2 : 1);
            default: nxt = mr ? 0 : m_state;
         endcase
         if (!pc && m_stall < 65535) m_stall++;
         if (m_state != 0) begin
            m_run_len++;
            if (m_run_len == TO) m_terr = 1;
         end
         if (nxt == 0) m_run_len = 0;
         m_state = nxt;
      end
   endtask

   task automatic idle();
      step(1, 4'd1, 4'd2, 1'b1, 1'b0, 4'd5, 0, 0, 0, 0);
   endtask

   // Monitor: checks every cycle the driver has scheduled an expectation for
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (q.size() > 0) begin
            e = q.pop_front();
            total++;
            if ({pc_we, s0_we, s1_we, s2_we, s3_we, s0_flush, s1_bubble} !== e.ctl) begin
               bad++;
               $display("FAIL ctl t=%0t got=%b exp=%b", $time,
                        {pc_we, s0_we, s1_we, s2_we, s3_we, s0_flush, s1_bubble}, e.ctl);
            end
            total++;
            if (ctrl_state !== e.st) begin
               bad++;
               $display("FAIL state t=%0t got=%0d exp=%0d", $time, ctrl_state, e.st);
            end
            total++;
            if (stall_cycles !== e.stall) begin
               bad++;
               $display("FAIL stall_cycles t=%0t got=%0d exp=%0d", $time, stall_cycles, e.stall);
            end
            total++;
            if (timeout_err !== e.terr) begin
               bad++;
               $display("FAIL timeout_err t=%0t got=%b exp=%b", $time, timeout_err, e.terr);
            end
         end
      end
   end

   initial begin
      // Reset state
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      idle();
      // Load-use on rs, then on rt
      step(1, 4'd3, 4'd7, 1'b0, 1'b1, 4'd3, 0, 0, 0, 0);
      idle();
      step(1, 4'd2, 4'd9, 1'b1, 1'b1, 4'd9, 0, 0, 0, 0);
      step(1, 4'd2, 4'd9, 1'b0, 1'b1, 4'd9, 0, 0, 0, 0);  // rt not read: no hazard
      // R0 never hazards
      step(1, 4'd0, 4'd0, 1'b1, 1'b1, 4'd0, 0, 0, 0, 0);
      idle();
      // Branch during IMISS
      step(1, 1, 2, 0, 0, 5, 0, 1, 0, 0);
      step(1, 1, 2, 0, 0, 5, 0, 1, 0, 0);
      step(1, 1, 2, 0, 0, 5, 1, 1, 0, 0);
      step(1, 1, 2, 0, 0, 5, 0, 1, 0, 0);
      step(1, 1, 2, 0, 0, 5, 0, 1, 0, 0);
      step(1, 1, 2, 0, 0, 5, 0, 1, 0, 1);
      idle();
      // D-miss together with a taken branch
      step(1, 1, 2, 0, 0, 5, 1, 0, 1, 0);
      for (int i = 0; i < 3; i++) step(1, 1, 2, 0, 0, 5, 1, 0, 1, 0);
      step(1, 1, 2, 0, 0, 5, 0, 0, 0, 1);
      step(1, 1, 2, 0, 0, 5, 1, 0, 0, 0);
      idle();
      // Stray mem_ready in RUN
      step(1, 1, 2, 0, 0, 5, 0, 0, 0, 1);
      // Watchdog
      for (int i = 0; i < 13; i++) step(1, 1, 2, 0, 0, 5, 0, 1, 0, 0);
      step(1, 1, 2, 0, 0, 5, 0, 1, 0, 1);
      idle(); idle();
      // Reset in the middle of a D-miss
      step(1, 1, 2, 0, 0, 5, 0, 0, 1, 0);
      step(1, 1, 2, 0, 0, 5, 0, 0, 1, 0);
      step(0, 1, 2, 0, 0, 5, 0, 0, 1, 0);
      idle(); idle();
      // Randomized traffic with occasional resets
      for (int i = 0; i < 3000; i++) begin
         step(($urandom_range(0, 199) != 0),
              4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 1'($urandom),
              1'($urandom), 4'($urandom_range(0, 3)),
              ($urandom_range(0, 6) == 0), ($urandom_range(0, 5) == 0),
              ($urandom_range(0, 9) == 0), ($urandom_range(0, 3) == 0));
      end
      idle();
      repeat (3) @(negedge clk);
      total++;
      if (q.size() != 0) begin
         bad++;
         $display("FAIL scoreboard_drain got=%0d exp=0", q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
